// File: rtl/acc_stream_pkg.sv
// rtl/acc_stream_pkg.sv - shared state encoding, sync default and width helpers for acc_streamer
package acc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } stream_state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    function automatic int idx_width(input int bytes);
        return $clog2(bytes + 2);
    endfunction

    function automatic int timer_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uart_tx_hs.sv
// rtl/uart_tx_hs.sv - one-byte UART handshake: strobe, wait for busy rise with retry, drain
module uart_tx_hs
    import acc_stream_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       tx_go,
    output logic [7:0] tx_data,
    output logic       byte_done
);

    localparam int TW = timer_width(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    stream_state_t state;
    stream_state_t state_next;
    logic [TW-1:0] timer;
    logic          load;

    // byte_done and go may coincide in DRAIN so the next byte goes straight to SEND
    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: state_next = ACK;
            ACK: begin
                if (tx_busy) begin
                    state_next = DRAIN;
                end else if (timer == TIMER_LAST) begin
                    state_next = SEND;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                    if (go) begin
                        load       = 1'b1;
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            tx_data <= 8'h00;
        end else begin
            state <= state_next;
            if (load) begin
                tx_data <= byte_in;
            end
            if (state == SEND) begin
                timer <= '0;
            end else if (state == ACK && !tx_busy) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign tx_go = (state == SEND);

endmodule

// File: rtl/acc_streamer.sv
// rtl/acc_streamer.sv - snapshots the accumulator on start and streams SYNC, data bytes LSB-first, XOR checksum
module acc_streamer
    import acc_stream_pkg::*;
#(
    parameter int         WIDTH       = 128,
    parameter logic [7:0] SYNC        = DEFAULT_SYNC,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] snapshot,
    input  logic             clr_overrun,
    input  logic             tx_busy,
    output logic             tx_go,
    output logic [7:0]       tx_data,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int BYTES = WIDTH / 8;
    localparam int IW    = idx_width(BYTES);
    localparam logic [IW-1:0] IDX_LAST_DATA = IW'(BYTES);
    localparam logic [IW-1:0] IDX_CSUM      = IW'(BYTES + 1);

    logic [WIDTH-1:0] shift;
    logic [7:0]       csum;
    logic [IW-1:0]    idx;
    logic             go;
    logic             byte_done;
    logic             accept;
    logic             advance;
    logic [7:0]       byte_next;

    assign accept  = start && !busy;
    assign advance = byte_done && (idx != IDX_CSUM);
    assign go      = accept || advance;

    // idx names the byte currently on the wire; byte_next is the one after it
    always_comb begin
        byte_next = SYNC;
        if (advance) begin
            byte_next = (idx == IDX_LAST_DATA) ? csum : shift[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            csum    <= 8'h00;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shift <= snapshot;
                csum  <= 8'h00;
                idx   <= '0;
                busy  <= 1'b1;
            end else if (advance) begin
                idx <= idx + 1'b1;
                if (idx != IDX_LAST_DATA) begin
                    shift <= shift >> 8;
                    csum  <= csum ^ shift[7:0];
                end
            end else if (byte_done) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (start && busy) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_tx_hs #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_tx_hs (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .byte_in  (byte_next),
        .tx_busy  (tx_busy),
        .tx_go    (tx_go),
        .tx_data  (tx_data),
        .byte_done(byte_done)
    );

endmodule
